// File: rtl/float_accum_seq.sv
// Accumulation sequencer around an external pipelined FP32 adder: feeds the running sum back as
// operand a and hands out the final sum. Optional zero/denormal bypass: FLOAT_ACC_ZERO_BYPASS_EN.
module float_accum_seq #(
    parameter int unsigned ADD_LATENCY = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_negate,
    input  logic [31:0]      add_out,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [31:0]      sum_data,
    output logic [CNT_W-1:0] sum_count
);

    typedef enum logic [1:0] {StIdle, StAcc, StWait, StDone} state_e;

    state_e             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        add_a_q, add_a_d;
    logic [31:0]        add_b_q, add_b_d;
    logic               add_neg_q, add_neg_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               last_q, last_d;
    logic               in_ready_q, in_ready_d;
    logic               sum_valid_q, sum_valid_d;

    logic               in_fire, sum_fire, use_adder;
    logic [31:0]        opnd;
    logic [CNT_W-1:0]   count_inc;

    assign in_fire   = in_valid & in_ready_q;
    assign sum_fire  = sum_valid_q & sum_ready;
    // Operand with the subtract folded into its sign, used when the adder is bypassed.
    assign opnd      = {in_data[31] ^ in_sub, in_data[30:0]};
    assign count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_neg_d = add_neg_q;
        cnt_d     = cnt_q;
        count_d   = count_q;
        last_d    = last_q;
        use_adder = 1'b1;

        case (state_q)
            StIdle: begin
                if (in_fire) begin
                    acc_d = opnd;
`ifdef FLOAT_ACC_ZERO_BYPASS_EN
                    if (in_data[30:23] == 8'd0) acc_d = '0;
`endif
                    count_d = CNT_W'(1);
                    state_d = in_last ? StDone : StAcc;
                end
            end
            StAcc: begin
                if (in_fire) begin
                    count_d = count_inc;
`ifdef FLOAT_ACC_ZERO_BYPASS_EN
                    if (in_data[30:23] == 8'd0) begin
                        use_adder = 1'b0;
                    end else if (acc_q[30:23] == 8'd0) begin
                        use_adder = 1'b0;
                        acc_d     = opnd;
                    end
`endif
                    if (use_adder) begin
                        add_a_d   = acc_q;
                        add_b_d   = in_data;
                        add_neg_d = in_sub;
                        cnt_d     = 3'(ADD_LATENCY);
                        last_d    = in_last;
                        state_d   = StWait;
                    end else begin
                        state_d = in_last ? StDone : StAcc;
                    end
                end
            end
            StWait: begin
                // Capture lands on the (ADD_LATENCY+1)th edge after acceptance.
                if (cnt_q == 3'd0) begin
                    acc_d   = add_out;
                    state_d = last_q ? StDone : StAcc;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StDone: begin
                if (sum_fire) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        in_ready_d  = (state_d == StIdle) || (state_d == StAcc);
        sum_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_neg_q   <= 1'b0;
            cnt_q       <= '0;
            count_q     <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_neg_q   <= add_neg_d;
            cnt_q       <= cnt_d;
            count_q     <= count_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign sum_valid  = sum_valid_q;
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign add_negate = add_neg_q;
    assign sum_data   = acc_q;
    assign sum_count  = count_q;

endmodule

// File: tb/tb_float_accum_seq.sv
// Bench for float_accum_seq: integer-valued floats through a latency-accurate adder model,
// directed scenarios plus randomized sums checked against a plain integer sum.
module tb_float_accum_seq;

    localparam int unsigned L  = 1;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_sub, in_last;
    logic [31:0]   in_data;
    logic [31:0]   add_a, add_b, add_out;
    logic          add_negate;
    logic          sum_valid, sum_ready;
    logic [31:0]   sum_data;
    logic [CW-1:0] sum_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int busy     = 0;
    bit mon_en   = 1'b0;
    int last_acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (mon_en && !in_ready && !sum_valid) busy++;

    float_accum_seq #(.ADD_LATENCY(L), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sub(in_sub), .in_last(in_last),
        .add_a(add_a), .add_b(add_b), .add_negate(add_negate), .add_out(add_out),
        .sum_valid(sum_valid), .sum_ready(sum_ready),
        .sum_data(sum_data), .sum_count(sum_count)
    );

    // Integer-valued float <-> integer conversions.
    function automatic longint f2i(input logic [31:0] f);
        int e;
        longint m, v;
        e = int'(f[30:23]);
        if (e == 0) return 0;
        m = longint'({1'b1, f[22:0]});
        if (e >= 150) v = m <<< (e - 150);
        else v = m >>> (150 - e);
        return f[31] ? -v : v;
    endfunction

    function automatic logic [31:0] i2f(input longint v);
        longint a, t;
        int p;
        logic [31:0] r;
        if (v == 0) return 32'h0;
        a = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 40; i++) if (a[i]) p = i;
        t = a << (23 - p);
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = t[22:0];
        return r;
    endfunction

    // Adder model: L registered stages.
    logic [31:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= i2f(f2i(add_a) + (add_negate ? -f2i(add_b) : f2i(add_b)));
        for (int i = 1; i < int'(L); i++) pipe[i] <= pipe[i-1];
    end
    assign add_out = pipe[L-1];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic push(input logic [31:0] d, input logic s, input logic l);
        int t;
        t = 0;
        in_valid = 1'b1; in_data = d; in_sub = s; in_last = l;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check_eq("push_timeout", 64'd0, 64'd1);
        @(negedge clk);
        last_acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_sum(output int waited);
        waited = 0;
        while (!sum_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!sum_valid) check_eq("sum_timeout", 64'd0, 64'd1);
    endtask

    task automatic pop(input logic [31:0] exp_d, input int exp_n);
        int w;
        wait_sum(w);
        check_eq("sum_data", 64'(sum_data), 64'(exp_d));
        check_eq("sum_count", 64'(sum_count), 64'(exp_n));
        sum_ready = 1'b1;
        @(negedge clk);
        sum_ready = 1'b0;
        check_eq("sum_valid_drop", 64'(sum_valid), 64'd0);
        check_eq("in_ready_after_sum", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int w, c2;
        logic [31:0] sa, sb;
        logic sn;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sub = 1'b0; in_last = 1'b0;
        sum_ready = 1'b0;
        #3;
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_sum_valid", 64'(sum_valid), 64'd0);
        check_eq("rst_add_a", 64'(add_a), 64'd0);
        check_eq("rst_add_neg", 64'(add_negate), 64'd0);
        check_eq("rst_sum_count", 64'(sum_count), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_ready", 64'(in_ready), 64'd1);

        // 1.0 + 2.0, capture timing
        push(32'h3F800000, 1'b0, 1'b0);
        push(32'h40000000, 1'b0, 1'b1);
        check_eq("t1_add_a", 64'(add_a), 64'h3F800000);
        check_eq("t1_add_b", 64'(add_b), 64'h40000000);
        check_eq("t1_wait_ready", 64'(in_ready), 64'd0);
        wait_sum(w);
        check_eq("t1_latency", 64'(w), 64'(L + 1));
        pop(32'h40400000, 2);

        // 3.0 - 1.0
        push(32'h40400000, 1'b0, 1'b0);
        push(32'h3F800000, 1'b1, 1'b1);
        check_eq("t2_negate", 64'(add_negate), 64'd1);
        pop(32'h40000000, 2);

        // single element, adder untouched
        sa = add_a; sb = add_b; sn = add_negate;
        push(32'h3F000000, 1'b1, 1'b1);
        pop(32'hBF000000, 1);
        check_eq("t3_add_a_held", 64'(add_a), 64'(sa));
        check_eq("t3_add_b_held", 64'(add_b), 64'(sb));
        check_eq("t3_neg_held", 64'(add_negate), 64'(sn));

        // four ones, consumer stalls; also steady-state spacing
        push(32'h3F800000, 1'b0, 1'b0);
        push(32'h3F800000, 1'b0, 1'b0);
        c2 = last_acc_cyc;
        push(32'h3F800000, 1'b0, 1'b0);
        check_eq("t4_throughput", 64'(last_acc_cyc - c2), 64'(L + 2));
        push(32'h3F800000, 1'b0, 1'b1);
        wait_sum(w);
        for (int i = 0; i < 5; i++) begin
            check_eq("t4_done_ready", 64'(in_ready), 64'd0);
            check_eq("t4_done_valid", 64'(sum_valid), 64'd1);
            check_eq("t4_done_data", 64'(sum_data), 64'h40800000);
            @(negedge clk);
        end
        pop(32'h40800000, 4);

        // async reset in WAIT abandons the sum
        push(32'h3F800000, 1'b0, 1'b0);
        push(32'h3F800000, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_in_ready", 64'(in_ready), 64'd0);
        check_eq("t5_add_a", 64'(add_a), 64'd0);
        check_eq("t5_add_b", 64'(add_b), 64'd0);
        check_eq("t5_sum_data", 64'(sum_data), 64'd0);
        check_eq("t5_sum_count", 64'(sum_count), 64'd0);
        check_eq("t5_sum_valid", 64'(sum_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t5_ready_again", 64'(in_ready), 64'd1);
        push(32'h40000000, 1'b0, 1'b0);
        push(32'h40000000, 1'b0, 1'b1);
        pop(32'h40800000, 2);

        // zero operand: bypass or adder
        busy = 0;
        mon_en = 1'b1;
        push(32'h3F800000, 1'b0, 1'b0);
        push(32'h00000000, 1'b0, 1'b0);
        push(32'h40000000, 1'b0, 1'b1);
        wait_sum(w);
        mon_en = 1'b0;
`ifdef FLOAT_ACC_ZERO_BYPASS_EN
        check_eq("t6_busy", 64'(busy), 64'(L + 1));
`else
        check_eq("t6_busy", 64'(busy), 64'(2 * (L + 1)));
`endif
        pop(32'h40400000, 3);

        // randomized sums of small nonzero integers
        for (int s = 0; s < 30; s++) begin
            int n;
            longint total, v;
            logic sub;
            n = int'($urandom_range(1, 6));
            total = 0;
            for (int k = 0; k < n; k++) begin
                v = longint'($urandom_range(1, 500));
                if ($urandom_range(0, 1) == 1) v = -v;
                sub = 1'($urandom_range(0, 1));
                total += sub ? -v : v;
                push(i2f(v), sub, k == n - 1);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pop(i2f(total), n);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/float_accum_seq.md
Name: float_accum_seq

Overview:
Sequencer that sits directly upstream and downstream of the single-precision floating adder. It accepts a stream of IEEE-754 single operands over a valid/ready handshake and drives the adder's a/b/negate inputs, feeding the running sum back as operand a. It captures the adder result after a fixed latency and, on the element flagged last, presents the final sum over a second valid/ready handshake.

Parameters:
ADD_LATENCY, 1, adder clock edges from stable a/b/negate to valid out (adder registers on posedge); range 1..7
CNT_W, 16, width of element counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand valid
in_ready  output  1  block can accept operand
in_data  input  32  operand, IEEE-754 single
in_sub  input  1  subtract this operand instead of adding it
in_last  input  1  operand is final element of this sum
add_a  output  32  to adder a (running sum), registered
add_b  output  32  to adder b (new operand), registered
add_negate  output  1  to adder negate, registered
add_out  input  32  from adder out
sum_valid  output  1  final sum available
sum_ready  input  1  consumer takes sum
sum_data  output  32  final sum
sum_count  output  CNT_W  elements accumulated into sum_data

Behaviour:
- Reset (rst_n low, async): state IDLE; in_ready, sum_valid, add_negate = 0; add_a, add_b, sum_data, sum_count, acc, wait counter = 0. A sum in progress is abandoned with no sum output.
- Transfer occurs on a rising edge with in_valid & in_ready (likewise sum_valid & sum_ready).
- in_ready = 1 only in IDLE and ACC. It is a registered/state decode and does not depend combinationally on in_valid.
- IDLE: on transfer, acc <= {in_data[31]^in_sub, in_data[30:0]}; count <= 1; go DONE if in_last, else ACC. The adder is not used.
- ACC: on transfer, add_a <= acc, add_b <= in_data, add_negate <= in_sub, cnt <= ADD_LATENCY, count <= count+1 (saturates at all-ones); latch in_last; go WAIT.
- WAIT: add_a/add_b/add_negate held stable. cnt decrements each edge. On the edge where cnt == 0, acc <= add_out, i.e. the capture happens on the (ADD_LATENCY+1)th rising edge after acceptance. Then go DONE if the latched last is set, else ACC.
- DONE: sum_valid = 1, sum_data = acc, sum_count = count, all stable until transfer. On transfer: sum_valid <= 0, go IDLE; in_ready is 1 in the following cycle.
- Throughput: one operand per ADD_LATENCY+2 cycles in steady state.
- No NaN/Inf/zero special-casing beyond the optional feature; acc takes whatever add_out returns.
- in_valid while in_ready = 0: ignored; the producer must hold its data.
- sum_ready while sum_valid = 0: ignored.

Optional Feature:
FLOAT_ACC_ZERO_BYPASS_EN.
- Defined:
  - In ACC, an operand with in_data[30:23] == 0 (zero/denormal) is counted but skips the adder. acc is unchanged, add_* registers are not updated, and the next state is DONE if in_last, else it stays in ACC (single-cycle accept).
  - In IDLE, a zero first operand sets acc = 0x00000000.
  - If acc has exponent 0 and the operand does not, acc <= {in_data[31]^in_sub, in_data[30:0]} directly without the adder.
- Undefined: every non-first operand goes through the adder as described above.

Test Plan:
1. Reset then 0x3F800000 (1.0), 0x40000000 (2.0, last), sum_ready=1 -> sum_data 0x40400000 (3.0), sum_count 2, sum_valid exactly one cycle; capture on 2nd edge after second acceptance with ADD_LATENCY=1.
2. 0x40400000 (3.0), then 0x3F800000 with in_sub=1, last -> add_negate=1 during WAIT, sum_data 0x40000000 (2.0).
3. Single element 0x3F000000 (0.5) with in_sub=1, last -> no adder activity (add_* unchanged), sum_data 0xBF000000, sum_count 1.
4. Four elements 1.0 each, last on 4th, sum_ready held 0 for 5 cycles -> in_ready=0 throughout DONE, sum_data 0x40800000 (4.0) stable, transfer when sum_ready=1, in_ready=1 next cycle.
5. rst_n pulled low during WAIT of a 3-element sum -> all outputs 0 immediately (async); new sequence 2.0, 2.0 (last) -> 0x40800000, sum_count 2.
6. With FLOAT_ACC_ZERO_BYPASS_EN: 1.0, 0x00000000, 2.0 (last) -> zero accepted without WAIT (in_ready stays 1), sum 0x40400000, sum_count 3; without the macro, the same stimulus passes the zero through the adder (WAIT entered twice).
